// File: rtl/m_sequence_gen_if.sv
// Packed-word output stream of the m-sequence generator: data/valid forward, ready back.
interface m_sequence_gen_if #(
  parameter int OUT_W = 8
) ();
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/m_sequence_gen.sv
// Fibonacci LFSR m-sequence generator with seed load, lock-up recovery, period marker
// and an OUT_W-bit word packer that backpressures the LFSR once a second word is full.
module m_sequence_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             m_seq,
  output logic [WIDTH-1:0] state,
  output logic             period_start,
  output logic             lockup,
  m_sequence_gen_if.master out_if
);

  localparam int               CNT_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(OUT_W - 1);
  localparam logic [WIDTH-1:0] STEP_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [OUT_W-1:0] shreg_q, shreg_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             period_start_q, period_start_d;
  logic             lockup_q, lockup_d;

  logic             fb;
  logic             emit_bit;
  logic             word_done;
  logic             stall;
  logic [OUT_W:0]   shift_ext;

  always_comb begin
    fb        = ^(state_q & TAPS);
    emit_bit  = state_q[WIDTH-1];
    word_done = (bit_cnt_q == LAST_BIT);
    // Hold only when the next bit would complete a word that has nowhere to go.
    stall     = out_valid_q && !out_if.out_ready && word_done;
    shift_ext = {shreg_q, emit_bit};

    state_d        = state_q;
    step_cnt_d     = step_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    period_start_d = 1'b0;
    lockup_d       = 1'b0;

    if (out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (load) begin
      state_d    = seed_in;
      step_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (state_q == '0) begin
      state_d    = SEED;
      step_cnt_d = '0;
      lockup_d   = 1'b1;
    end else if (en && !stall) begin
      state_d        = {state_q[WIDTH-2:0], fb};
      step_cnt_d     = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + 1'b1;
      period_start_d = (step_cnt_q == '0);
      shreg_d        = shift_ext[OUT_W-1:0];
      if (word_done) begin
        out_data_d  = shift_ext[OUT_W-1:0];
        out_valid_d = 1'b1;
        bit_cnt_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SEED;
      step_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      period_start_q <= 1'b0;
      lockup_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_cnt_q     <= step_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      period_start_q <= period_start_d;
      lockup_q       <= lockup_d;
    end
  end

  assign m_seq            = state_q[WIDTH-1];
  assign state            = state_q;
  assign period_start     = period_start_q;
  assign lockup           = lockup_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule
